reg_scoreboard: RTL and testbench

- Tracks pending register writes in the RISC pipeline and stalls issue on RAW/WAW hazards.
- Works on the 5-bit destination register number produced by the write-register select logic. It converts that number back into a per-register "busy" state and checks source operands against it.
- Sits between decode and issue. Issue logic consumes `stall`; write-back drives the explicit clear.

---
 rtl/reg_scoreboard_if.sv | 28 ++
 rtl/reg_scoreboard.sv | 62 ++++++
 tb/tb_reg_scoreboard.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode/issue/write-back signal bundle for the register scoreboard.
interface reg_scoreboard_if #(
   parameter int NREGS = 32,
   parameter int AW    = 5,
   parameter int LW    = 3
);
   logic             issue_valid;
   logic             issue_wen;
   logic [AW-1:0]    issue_rd;
   logic [LW-1:0]    issue_lat;
   logic [AW-1:0]    src1;
   logic [AW-1:0]    src2;
   logic             wb_valid;
   logic [AW-1:0]    wb_rd;
   logic             flush;
   logic             stall;
   logic             issue_fire;
   logic [NREGS-1:0] busy_vec;
   logic [5:0]       pending_cnt;
   modport master (
      output issue_valid, issue_wen, issue_rd, issue_lat, src1, src2, wb_valid, wb_rd, flush,
      input  stall, issue_fire, busy_vec, pending_cnt
   );
   modport slave (
      input  issue_valid, issue_wen, issue_rd, issue_lat, src1, src2, wb_valid, wb_rd, flush,
      output stall, issue_fire, busy_vec, pending_cnt
   );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy tracking with timed countdown and write-back release;
// stalls issue on RAW/WAW hazards.
module reg_scoreboard #(
   parameter int NREGS = 32,
   parameter int AW    = 5,
   parameter int LW    = 3
) (
   input logic            clk,
   input logic            rst_n,
   reg_scoreboard_if.slave bus
);
   logic [NREGS-1:0][LW-1:0] r_cnt, w_cnt_nxt;
   logic [NREGS-1:0]         r_wait_wb, w_wait_nxt, w_busy, w_haz, w_busy_nxt;
   logic [5:0]               r_pending, w_pop;
   logic                     w_stall;
   // cnt == 1 is forwarded next cycle, so only cnt > 1 counts as a hazard
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         w_busy[r] = (r_cnt[r] != '0) || r_wait_wb[r];
         w_haz[r]  = (r_cnt[r] > LW'(1)) || r_wait_wb[r];
      end
   end
   assign w_stall        = bus.issue_valid && (w_haz[bus.src1] || w_haz[bus.src2] ||
                                               (bus.issue_wen && w_haz[bus.issue_rd]));
   assign bus.stall      = w_stall;
   assign bus.issue_fire = bus.issue_valid && !w_stall;
   assign bus.busy_vec   = w_busy;
   assign bus.pending_cnt = r_pending;
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_wait_nxt = r_wait_wb;
      w_pop      = '0;
      for (int r = 0; r < NREGS; r++)
         w_cnt_nxt[r] = (r_cnt[r] != '0) ? r_cnt[r] - LW'(1) : '0;
      if (bus.wb_valid && bus.wb_rd != '0)
         w_wait_nxt[bus.wb_rd] = 1'b0;
      // issue overrides a same-cycle write-back to the same register
      if (bus.issue_valid && !w_stall && bus.issue_wen && bus.issue_rd != '0) begin
         w_cnt_nxt[bus.issue_rd]  = bus.issue_lat;
         w_wait_nxt[bus.issue_rd] = (bus.issue_lat == '0);
      end
      if (bus.flush) begin
         w_cnt_nxt  = '0;
         w_wait_nxt = '0;
      end
      for (int r = 0; r < NREGS; r++) begin
         w_busy_nxt[r] = (w_cnt_nxt[r] != '0) || w_wait_nxt[r];
         w_pop         = w_pop + 6'(w_busy_nxt[r]);
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_wait_wb <= '0;
         r_pending <= '0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_wait_wb <= w_wait_nxt;
         r_pending <= w_pop;
      end
   end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: scenario tasks plus randomized run against a ready-time reference model.
module tb_reg_scoreboard;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;
   reg_scoreboard_if bus ();
   reg_scoreboard dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int errors = 0;
   int checks = 0;
   // model: a timed register is busy until cycle m_ready; untimed ones until written back
   int m_ready[32];
   bit m_wb[32];
   int cur = 0;
   function automatic bit m_busy(int r);
      return r != 0 && (m_ready[r] > cur || m_wb[r]);
   endfunction
   function automatic bit m_haz(int r);
      return r != 0 && (m_ready[r] > cur + 1 || m_wb[r]);
   endfunction
   function automatic bit exp_stall();
      return bus.issue_valid && (m_haz(int'(bus.src1)) || m_haz(int'(bus.src2)) ||
                                 (bus.issue_wen && m_haz(int'(bus.issue_rd))));
   endfunction
   function automatic logic [31:0] exp_vec();
      logic [31:0] v = '0;
      for (int r = 0; r < 32; r++) v[r] = m_busy(r);
      return v;
   endfunction
   task automatic model_clear();
      for (int r = 0; r < 32; r++) begin
         m_ready[r] = 0;
         m_wb[r] = 1'b0;
      end
   endtask
   task automatic drive(bit v, bit wen, int rd, int lat, int s1, int s2,
                        bit wbv = 1'b0, int wbrd = 0, bit fl = 1'b0);
      bus.issue_valid = v;
      bus.issue_wen   = wen;
      bus.issue_rd    = 5'(rd);
      bus.issue_lat   = 3'(lat);
      bus.src1        = 5'(s1);
      bus.src2        = 5'(s2);
      bus.wb_valid    = wbv;
      bus.wb_rd       = 5'(wbrd);
      bus.flush       = fl;
      #1;
   endtask
   task automatic tick();
      bit fire;
      fire = bus.issue_valid && !exp_stall();
      if (bus.flush) model_clear();
      else begin
         if (bus.wb_valid && bus.wb_rd != 0) m_wb[bus.wb_rd] = 1'b0;
         if (fire && bus.issue_wen && bus.issue_rd != 0) begin
            m_ready[bus.issue_rd] = (bus.issue_lat != 0) ? cur + int'(bus.issue_lat) + 1 : 0;
            m_wb[bus.issue_rd]    = (bus.issue_lat == 0);
         end
      end
      @(posedge clk);
      #1;
      cur++;
   endtask
   task automatic idle(int n);
      repeat (n) begin
         drive(0, 0, 0, 0, 0, 0);
         tick();
      end
   endtask
   task automatic test_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", bus.busy_vec); end
      checks++; if (bus.pending_cnt !== 6'd0) begin errors++; $display("FAIL reset_pending: got %0d want 0", bus.pending_cnt); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
      rst_n = 1'b1;
      drive(1, 1, 5, 2, 3, 4);
      checks++; if (bus.stall !== 1'b0 || bus.issue_fire !== 1'b1) begin errors++; $display("FAIL first_issue: stall=%b fire=%b want 0/1", bus.stall, bus.issue_fire); end
      tick();
      checks++; if (bus.busy_vec !== 32'h0000_0020) begin errors++; $display("FAIL first_busy: got %h want 00000020", bus.busy_vec); end
      checks++; if (bus.pending_cnt !== 6'd1) begin errors++; $display("FAIL first_pending: got %0d want 1", bus.pending_cnt); end
      idle(3);
      checks++; if (bus.busy_vec !== 32'h0) begin errors++; $display("FAIL first_release: got %h want 0", bus.busy_vec); end
   endtask
   task automatic test_timed_raw();
      bit exp_s[3] = '{1'b1, 1'b1, 1'b0};
      drive(1, 1, 5, 3, 0, 0);
      checks++; if (bus.issue_fire !== 1'b1) begin errors++; $display("FAIL raw_issue: fire=%b want 1", bus.issue_fire); end
      tick();
      for (int k = 0; k < 3; k++) begin
         checks++; if (bus.busy_vec[5] !== 1'b1) begin errors++; $display("FAIL raw_busy%0d: got %b want 1", k, bus.busy_vec[5]); end
         drive(1, 0, 0, 0, 5, 0);
         checks++; if (bus.stall !== exp_s[k]) begin errors++; $display("FAIL raw_stall%0d: got %b want %b", k, bus.stall, exp_s[k]); end
         tick();
      end
      checks++; if (bus.busy_vec[5] !== 1'b0) begin errors++; $display("FAIL raw_release: got %b want 0", bus.busy_vec[5]); end
   endtask
   task automatic test_untimed();
      idle(2);
      drive(1, 1, 7, 0, 0, 0);
      tick();
      for (int k = 0; k < 5; k++) begin
         drive(1, 0, 0, 0, 0, 7);
         checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL load_stall%0d: got %b want 1", k, bus.stall); end
         tick();
      end
      checks++; if (bus.pending_cnt !== 6'd1) begin errors++; $display("FAIL load_pending: got %0d want 1", bus.pending_cnt); end
      drive(1, 0, 0, 0, 0, 7, 1, 7);
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL load_no_bypass: got %b want 1", bus.stall); end
      tick();
      checks++; if (bus.pending_cnt !== 6'd0 || bus.busy_vec !== 32'h0) begin errors++; $display("FAIL load_wb: pending=%0d busy=%h want 0/0", bus.pending_cnt, bus.busy_vec); end
      drive(1, 0, 0, 0, 0, 7);
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL load_resume: got %b want 0", bus.stall); end
      tick();
   endtask
   task automatic test_waw();
      drive(1, 1, 9, 0, 0, 0);
      tick();
      drive(1, 1, 9, 2, 0, 0);
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %b want 1", bus.stall); end
      tick();
      drive(1, 1, 9, 0, 0, 0, 1, 9);
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL waw_wb_stall: got %b want 1", bus.stall); end
      tick();
      checks++; if (bus.busy_vec[9] !== 1'b0) begin errors++; $display("FAIL waw_wb_clear: got %b want 0", bus.busy_vec[9]); end
      drive(1, 1, 9, 1, 0, 0);
      tick();
      drive(1, 1, 9, 0, 0, 0, 1, 9);
      checks++; if (bus.issue_fire !== 1'b1) begin errors++; $display("FAIL wbiss_fire: got %b want 1", bus.issue_fire); end
      tick();
      idle(2);
      checks++; if (bus.busy_vec[9] !== 1'b1) begin errors++; $display("FAIL wbiss_kept: got %b want 1", bus.busy_vec[9]); end
      drive(0, 0, 0, 0, 0, 0, 1, 9);
      tick();
      checks++; if (bus.busy_vec !== 32'h0) begin errors++; $display("FAIL wbiss_release: got %h want 0", bus.busy_vec); end
   endtask
   task automatic test_r0_flush();
      drive(1, 1, 0, 4, 0, 0);
      checks++; if (bus.issue_fire !== 1'b1) begin errors++; $display("FAIL r0_fire: got %b want 1", bus.issue_fire); end
      tick();
      checks++; if (bus.busy_vec !== 32'h0 || bus.pending_cnt !== 6'd0) begin errors++; $display("FAIL r0_busy: busy=%h pending=%0d want 0/0", bus.busy_vec, bus.pending_cnt); end
      drive(1, 1, 2, 0, 0, 0); tick();
      drive(1, 1, 3, 5, 0, 0); tick();
      drive(1, 1, 4, 0, 0, 0); tick();
      checks++; if (bus.busy_vec !== 32'h0000_001C || bus.pending_cnt !== 6'd3) begin errors++; $display("FAIL flush_pre: busy=%h pending=%0d want 0000001c/3", bus.busy_vec, bus.pending_cnt); end
      drive(1, 1, 6, 0, 0, 0, 0, 0, 1);
      tick();
      checks++; if (bus.busy_vec !== 32'h0 || bus.pending_cnt !== 6'd0) begin errors++; $display("FAIL flush_clear: busy=%h pending=%0d want 0/0", bus.busy_vec, bus.pending_cnt); end
   endtask
   task automatic test_async_reset();
      drive(1, 1, 10, 0, 0, 0); tick();
      drive(1, 1, 11, 5, 0, 0); tick();
      checks++; if (bus.pending_cnt !== 6'd2) begin errors++; $display("FAIL arst_pre: got %0d want 2", bus.pending_cnt); end
      drive(0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      checks++; if (bus.busy_vec !== 32'h0 || bus.pending_cnt !== 6'd0) begin errors++; $display("FAIL arst_clear: busy=%h pending=%0d want 0/0", bus.busy_vec, bus.pending_cnt); end
      #1 rst_n = 1'b1;
      model_clear();
      tick();
      drive(1, 0, 0, 0, 10, 0);
      checks++; if (bus.stall !== 1'b0 || bus.issue_fire !== 1'b1) begin errors++; $display("FAIL arst_issue: stall=%b fire=%b want 0/1", bus.stall, bus.issue_fire); end
      tick();
   endtask
   task automatic test_random();
      bit v, es;
      for (int i = 0; i < 600; i++) begin
         v = $urandom_range(0, 3) != 0;
         drive(v, 1'($urandom_range(0, 1)), int'($urandom_range(0, 12)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 12)), int'($urandom_range(0, 12)), $urandom_range(0, 2) == 0,
               int'($urandom_range(0, 12)), $urandom_range(0, 40) == 0);
         es = exp_stall();
         checks++; if (bus.stall !== es || bus.issue_fire !== (v && !es)) begin errors++; $display("FAIL rnd_stall@%0d: stall=%b fire=%b want %b/%b", i, bus.stall, bus.issue_fire, es, v && !es); end
         tick();
         checks++; if (bus.busy_vec !== exp_vec() || bus.pending_cnt !== 6'($countones(exp_vec()))) begin errors++; $display("FAIL rnd_state@%0d: busy=%h pending=%0d want %h/%0d", i, bus.busy_vec, bus.pending_cnt, exp_vec(), $countones(exp_vec())); end
      end
   endtask
   initial begin
      test_reset();
      test_timed_raw();
      test_untimed();
      test_waw();
      test_r0_flush();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
